dmem_arbiter: RTL

//  Two-requester round-robin arbiter and sequencer for the single-port word data memory
//  (32 x 32-bit, byte address, word index = addr[6:2], sync write, async read).

---
 rtl/dmem_arbiter.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter/sequencer for two requesters sharing a single-port word data memory.
// Each access takes a fixed IDLE -> ACCESS -> RESP sequence; bad addresses are rejected without touching memory.
module dmem_arbiter #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  output logic        p0_ack,
  output logic        p0_err,
  output logic [31:0] p0_rdata,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  output logic        p1_ack,
  output logic        p1_err,
  output logic [31:0] p1_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_write,
  output logic        mem_read,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        gnt_id
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } state_e;

  state_e      state_q;
  logic        last_gnt_q;
  logic        gnt_q;
  logic        we_q;
  logic        err_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        p0_ack_q, p1_ack_q;
  logic        p0_err_q, p1_err_q;
  logic [31:0] p0_rdata_q, p1_rdata_q;

  logic        win_d;
  logic        sel_we_d;
  logic [31:0] sel_addr_d;
  logic [31:0] sel_wdata_d;
  logic        sel_err_d;
  logic [AW:0] sel_idx;
  logic [31:0] rdata_d;
  logic        in_access;

  // Single requester wins outright; on a tie the one not granted last time wins.
  always_comb begin
    win_d = 1'b0;
    if (p0_req && p1_req) begin
      win_d = ~last_gnt_q;
    end else if (p1_req) begin
      win_d = 1'b1;
    end
  end

  always_comb begin
    sel_we_d    = win_d ? p1_we    : p0_we;
    sel_addr_d  = win_d ? p1_addr  : p0_addr;
    sel_wdata_d = win_d ? p1_wdata : p0_wdata;
  end

  // Range check split so it holds for any DEPTH up to 2**AW.
  always_comb begin
    sel_idx   = {1'b0, sel_addr_d[AW+1:2]};
    sel_err_d = (sel_addr_d[1:0] != 2'b00)
              | (sel_addr_d[31:AW+2] != '0)
              | (sel_idx >= (AW+1)'(DEPTH));
  end

  always_comb begin
    rdata_d = '0;
    if (!we_q && !err_q) begin
      rdata_d = mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      last_gnt_q <= 1'b1;
      gnt_q      <= 1'b0;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      p0_ack_q   <= 1'b0;
      p1_ack_q   <= 1'b0;
      p0_err_q   <= 1'b0;
      p1_err_q   <= 1'b0;
      p0_rdata_q <= '0;
      p1_rdata_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (p0_req || p1_req) begin
            gnt_q      <= win_d;
            last_gnt_q <= win_d;
            we_q       <= sel_we_d;
            addr_q     <= sel_addr_d;
            wdata_q    <= sel_wdata_d;
            err_q      <= sel_err_d;
            state_q    <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (gnt_q) begin
            p1_ack_q   <= 1'b1;
            p1_err_q   <= err_q;
            p1_rdata_q <= rdata_d;
          end else begin
            p0_ack_q   <= 1'b1;
            p0_err_q   <= err_q;
            p0_rdata_q <= rdata_d;
          end
          state_q <= S_RESP;
        end
        S_RESP: begin
          p0_ack_q   <= 1'b0;
          p1_ack_q   <= 1'b0;
          p0_err_q   <= 1'b0;
          p1_err_q   <= 1'b0;
          p0_rdata_q <= '0;
          p1_rdata_q <= '0;
          state_q    <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Memory strobes come straight off the latched command; reset gates the write in the same cycle.
  assign in_access = (state_q == S_ACCESS);
  assign mem_addr  = in_access ? addr_q  : '0;
  assign mem_wdata = in_access ? wdata_q : '0;
  assign mem_write = in_access & we_q & ~err_q & ~reset;
  assign mem_read  = in_access & ~we_q & ~err_q;

  assign busy     = (state_q != S_IDLE);
  assign gnt_id   = gnt_q;
  assign p0_ack   = p0_ack_q;
  assign p1_ack   = p1_ack_q;
  assign p0_err   = p0_err_q;
  assign p1_err   = p1_err_q;
  assign p0_rdata = p0_rdata_q;
  assign p1_rdata = p1_rdata_q;

endmodule
